serial_adder: RTL and testbench

- Parametrised bit-serial adder/subtractor built around a chain of STEP full-adder cells.
- Processes STEP bits per clock and produces a WIDTH-bit result after WIDTH/STEP cycles, using a start/busy/done handshake.
- Generalises the single-bit full adder and the 4-bit register into a multi-cycle arithmetic unit with an add/sub mode.
- Sits on the datapath as a low-area alternative to a full-width ripple adder.

---
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, STEP bits per clock, start/busy/done handshake
//
// Optional tri-state result bus: define SERIAL_ADDER_TRI_EN to add input oe and
// output y; y drives s while oe && done and floats otherwise.
//
// Operation latency is N = WIDTH/STEP clocks from the accepting edge to done.
// Subtraction is performed as a + ~b + 1: b is inverted at capture and the
// chain carry is seeded with 1, so cout=1 means "no borrow".

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
`ifdef SERIAL_ADDER_TRI_EN
  ,
  input  logic             oe,
  output tri   [WIDTH-1:0] y
`endif
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject parameter combinations that cannot be processed in whole chunks.
  generate
    if (WIDTH < 2) begin : g_width_check
      $error("serial_adder: WIDTH must be >= 2");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_step_range_check
      $error("serial_adder: STEP must be in 1..WIDTH");
    end else if ((WIDTH % STEP) != 0) begin : g_step_div_check
      $error("serial_adder: WIDTH must be a multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    count;
  logic             carry;

  logic [STEP:0]    chain_c;
  logic [STEP-1:0]  chunk;
  logic [WIDTH-1:0] sum_next;

  // Cascade of STEP full-adder cells over the low chunk of the operand shifters.
  always_comb begin
    chain_c    = '0;
    chunk      = '0;
    chain_c[0] = carry;
    for (int i = 0; i < STEP; i++) begin
      chunk[i]       = op_a[i] ^ op_b[i] ^ chain_c[i];
      chain_c[i+1]   = (op_a[i] & op_b[i]) | (chain_c[i] & (op_a[i] ^ op_b[i]));
    end
  end

  // New chunk enters at the top of the sum register; after N chunks the LSB chunk sits at bit 0.
  always_comb begin
    sum_next = WIDTH'({chunk, sum_sr} >> STEP);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      count  <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub;
            count  <= '0;
            sum_sr <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          op_a   <= op_a >> STEP;
          op_b   <= op_b >> STEP;
          sum_sr <= sum_next;
          carry  <= chain_c[STEP];
          count  <= count + CW'(1);
          if (count == LAST) begin
            // Last chunk holds the MSB: its incoming and outgoing carries give signed overflow.
            s     <= sum_next;
            cout  <= chain_c[STEP];
            ovf   <= chain_c[STEP-1] ^ chain_c[STEP];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_TRI_EN
  assign y = (oe && done) ? s : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (STEP=1 and STEP=4 instances)

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_v [2];
  logic       sub_v   [2];
  logic [7:0] a_v     [2];
  logic [7:0] b_v     [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [7:0] s_v     [2];
  logic       cout_v  [2];
  logic       ovf_v   [2];
`ifdef SERIAL_ADDER_TRI_EN
  logic       oe_v    [2];
  tri   [7:0] y0;
  tri   [7:0] y1;
`endif

  serial_adder #(.WIDTH(8), .STEP(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
`ifdef SERIAL_ADDER_TRI_EN
    , .oe(oe_v[0]), .y(y0)
`endif
  );

  serial_adder #(.WIDTH(8), .STEP(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
`ifdef SERIAL_ADDER_TRI_EN
    , .oe(oe_v[1]), .y(y1)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected {cout, ovf, s}
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  int         acc [2];
  int         bc  [2];
  logic       pd  [2];
  logic [9:0] ps  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic sb);
    int ux, uy, sx, sy, ur, sr;
    logic c, v;
    logic [7:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ur = sb ? (ux - uy) : (ux + uy);
    sr = sb ? (sx - sy) : (sx + sy);
    r  = 8'(ur);
    c  = sb ? (ux >= uy) : (ur > 255);
    v  = (sr > 127) || (sr < -128);
    return {c, v, r};
  endfunction

  // Per-instance monitor: pops on each completion, otherwise demands the result stays put.
  task automatic mon(input int k);
    logic [9:0] e;
    int n;
    n = (k == 0) ? 8 : 2;
    if (reset) begin
      bc[k] = 0;
    end else begin
      chk($sformatf("busy_done_excl%0d", k), {31'd0, busy_v[k] & done_v[k]}, 32'd0);
      if (done_v[k] && !pd[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done%0d actual=done required=no_pending_op", k);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("s%0d", k),    {24'd0, s_v[k]},    {24'd0, e[7:0]});
          chk($sformatf("cout%0d", k), {31'd0, cout_v[k]}, {31'd0, e[9]});
          chk($sformatf("ovf%0d", k),  {31'd0, ovf_v[k]},  {31'd0, e[8]});
          chk($sformatf("latency%0d", k), cyc - acc[k], n);
          chk($sformatf("busy_len%0d", k), bc[k], n);
        end
        bc[k] = 0;
      end else begin
        chk($sformatf("hold%0d", k), {22'd0, cout_v[k], ovf_v[k], s_v[k]}, {22'd0, ps[k]});
      end
      if (busy_v[k]) bc[k]++;
    end
    pd[k] = done_v[k];
    ps[k] = {cout_v[k], ovf_v[k], s_v[k]};
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a posedge with the instance in IDLE or DONE.
  task automatic issue(input int k, input logic [7:0] x, input logic [7:0] y, input logic sb);
    a_v[k]     = x;
    b_v[k]     = y;
    sub_v[k]   = sb;
    start_v[k] = 1'b1;
    tick(1);
    start_v[k] = 1'b0;
    a_v[k]     = 8'($urandom);
    b_v[k]     = 8'($urandom);
    sub_v[k]   = 1'($urandom);
    acc[k]     = cyc;
    if (k == 0) q0.push_back(model(x, y, sb));
    else        q1.push_back(model(x, y, sb));
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!done_v[k]) begin
      tick(1);
      n++;
      if (n > 40) begin
        checks++;
        failures++;
        $display("FAIL done_timeout%0d actual=no_done required=done_within_40", k);
        return;
      end
    end
  endtask

  task automatic chk_reset_state(input int k);
    chk($sformatf("rst_busy%0d", k), {31'd0, busy_v[k]}, 32'd0);
    chk($sformatf("rst_done%0d", k), {31'd0, done_v[k]}, 32'd0);
    chk($sformatf("rst_cout%0d", k), {31'd0, cout_v[k]}, 32'd0);
    chk($sformatf("rst_ovf%0d", k),  {31'd0, ovf_v[k]},  32'd0);
    chk($sformatf("rst_s%0d", k),    {24'd0, s_v[k]},    32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      sub_v[k]   = 1'b0;
      a_v[k]     = 8'h00;
      b_v[k]     = 8'h00;
      acc[k]     = 0;
      bc[k]      = 0;
      pd[k]      = 1'b0;
      ps[k]      = 10'd0;
`ifdef SERIAL_ADDER_TRI_EN
      oe_v[k]    = 1'b0;
`endif
    end
    tick(2);
    reset = 1'b0;
    chk_reset_state(0);
    chk_reset_state(1);
    tick(3);
    chk("idle_done0", {31'd0, done_v[0]}, 32'd0);

    // Directed cases on the STEP=1 instance.
    issue(0, 8'h3C, 8'h05, 1'b0);
    wait_done(0);
    issue(0, 8'h7F, 8'h01, 1'b0);
    wait_done(0);
    issue(0, 8'hFF, 8'h01, 1'b0);
    chk("b2b_done_drop", {31'd0, done_v[0]}, 32'd0);
    chk("b2b_busy_rise", {31'd0, busy_v[0]}, 32'd1);
    chk("b2b_s_held",    {24'd0, s_v[0]},    32'h80);
    chk("b2b_ovf_held",  {31'd0, ovf_v[0]},  32'd1);
    wait_done(0);
    issue(0, 8'h05, 8'h07, 1'b1);
    wait_done(0);
    issue(0, 8'h80, 8'h01, 1'b1);
    wait_done(0);

    // start during RUN must be ignored.
    issue(0, 8'h10, 8'h20, 1'b0);
    tick(2);
    a_v[0] = 8'hAA;
    b_v[0] = 8'h55;
    start_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    wait_done(0);
    chk("ignored_start_s", {24'd0, s_v[0]}, 32'h30);

    // Reset mid-RUN with start held high aborts without any result.
    issue(0, 8'($urandom), 8'($urandom), 1'b0);
    tick(3);
    reset = 1'b1;
    start_v[0] = 1'b1;
    a_v[0] = 8'($urandom);
    b_v[0] = 8'($urandom);
    tick(2);
    reset = 1'b0;
    start_v[0] = 1'b0;
    q0.delete();
    chk_reset_state(0);
    tick(12);
    chk("post_rst_done0", {31'd0, done_v[0]}, 32'd0);
    chk("post_rst_busy0", {31'd0, busy_v[0]}, 32'd0);

    // STEP=4 instance.
    issue(1, 8'hF0, 8'h1F, 1'b0);
    wait_done(1);
    chk("step4_s", {24'd0, s_v[1]}, 32'h0F);
`ifdef SERIAL_ADDER_TRI_EN
    chk("tri_oe0", {24'd0, y1}, {24'd0, 8'bzzzzzzzz});
    oe_v[1] = 1'b1;
    #1;
    chk("tri_oe1", {24'd0, y1}, 32'h0F);
    issue(1, 8'h01, 8'h01, 1'b0);
    chk("tri_notdone", {24'd0, y1}, {24'd0, 8'bzzzzzzzz});
    wait_done(1);
    oe_v[1] = 1'b0;
`endif

    // Randomized traffic on both instances, mixing back-to-back and gapped starts.
    for (int i = 0; i < 60; i++) begin
      int k;
      k = i % 2;
      issue(k, 8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tick(1);
        a_v[k] = 8'($urandom);
        b_v[k] = 8'($urandom);
        start_v[k] = 1'b1;
        tick(1);
        start_v[k] = 1'b0;
      end
      wait_done(k);
      tick($urandom_range(0, 2));
    end

    tick(3);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
